// File: rtl/if_id_skid_reg_if.sv
// Handshake bundle between fetch, the IF/ID skid register and decode.
// slave is the register's own view; master is the fetch/decode side driving it.
interface if_id_skid_reg_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [PC_WIDTH-1:0]             current_PC;
    logic [INSTR_WIDTH-1:0]          instruction;
    logic                            in_valid;
    logic                            in_ready;
    logic                            flush;
    logic [PC_WIDTH+INSTR_WIDTH-1:0] out;
    logic                            out_valid;
    logic                            out_ready;
    logic [1:0]                      count;

    modport slave (
        input  current_PC,
        input  instruction,
        input  in_valid,
        input  flush,
        input  out_ready,
        output in_ready,
        output out,
        output out_valid,
        output count
    );

    modport master (
        output current_PC,
        output instruction,
        output in_valid,
        output flush,
        output out_ready,
        input  in_ready,
        input  out,
        input  out_valid,
        input  count
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer and synchronous flush.
// Fetch may stream one beat past a decode stall; a redirect squashes everything held.
module if_id_skid_reg #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    if_id_skid_reg_if.slave      bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [PC_WIDTH-1:0]     r_mainPc;
    logic [INSTR_WIDTH-1:0]  r_mainInstr;
    logic [PC_WIDTH-1:0]     r_skidPc;
    logic [INSTR_WIDTH-1:0]  r_skidInstr;

    logic w_inReady;
    logic w_outValid;
    logic w_inFire;
    logic w_outFire;
    logic w_loadMainIn;
    logic w_loadMainSkid;
    logic w_loadSkid;
    logic [1:0] w_count;

    // Readiness depends only on registered state, so no out_ready->in_ready path exists.
    assign w_inReady  = (r_state != S_FULL);
    assign w_outValid = (r_state != S_EMPTY);
    assign w_inFire   = bus.in_valid & w_inReady;
    assign w_outFire  = w_outValid & bus.out_ready;

    always_comb begin
        w_nextState    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        if (bus.flush) begin
            w_nextState = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_inFire) begin
                        w_loadMainIn = 1'b1;
                        w_nextState  = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_inFire && w_outFire) begin
                        w_loadMainIn = 1'b1;
                    end else if (w_outFire) begin
                        w_nextState = S_EMPTY;
                    end else if (w_inFire) begin
                        w_loadSkid  = 1'b1;
                        w_nextState = S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_outFire) begin
                        w_loadMainSkid = 1'b1;
                        w_nextState    = S_ONE;
                    end
                end
                default: w_nextState = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Data is left untouched by flush; the cleared state already masks it from out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mainPc    <= '0;
            r_mainInstr <= '0;
            r_skidPc    <= '0;
            r_skidInstr <= '0;
        end else begin
            if (w_loadMainIn) begin
                r_mainPc    <= bus.current_PC;
                r_mainInstr <= bus.instruction;
            end else if (w_loadMainSkid) begin
                r_mainPc    <= r_skidPc;
                r_mainInstr <= r_skidInstr;
            end
            if (w_loadSkid) begin
                r_skidPc    <= bus.current_PC;
                r_skidInstr <= bus.instruction;
            end
        end
    end

    always_comb begin
        w_count = 2'd0;
        case (r_state)
            S_ONE:   w_count = 2'd1;
            S_FULL:  w_count = 2'd2;
            default: w_count = 2'd0;
        endcase
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.count     = w_count;
    assign bus.out       = w_outValid ? {r_mainPc, r_mainInstr}
                                      : {{PC_WIDTH{1'b0}}, NOP_INSTR};

endmodule
